run_launcher: RTL and testbench

Run controller for the lab accelerator datapath: turns a debounced push-button level into a one-cycle `start` pulse to the accelerator and drives the active-low-while-busy `done` status that the cycle measurement logic consumes. It sits between the board I/O (button, LEDs) and the accelerator, and enforces a timeout so that a hung accelerator cannot hold `done` low indefinitely. It also keeps a count of successfully completed runs for display.

---
 rtl/run_launcher_pkg.sv | 16 +
 rtl/run_launcher_rise_detect.sv | 26 ++
 rtl/run_launcher.sv | 92 +++++++++
 tb/tb_run_launcher.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/run_launcher_pkg.sv
// Shared definitions for the run launcher: state encodings used by the FSM
// and by the board-level debug LEDs, plus a small state-decode helper.
package run_launcher_pkg;

    // State encodings (2-bit, kept as plain constants so legacy display logic
    // can compare against them directly).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    // A run is in progress from the launch cycle until the FSM returns to IDLE.
    function automatic logic is_busy(input logic [1:0] state);
        return (state == ST_LAUNCH) || (state == ST_RUN);
    endfunction

endpackage

// File: rtl/run_launcher_rise_detect.sv
// Rising-edge detector for a debounced level input. Holds the previous-cycle
// copy of the input; reusable for any other button on the board.
module rise_detect
    import run_launcher_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic rise
);

    logic r_in_q;

    // Track the input every cycle regardless of what the consumer is doing,
    // so a level held across a busy period never looks like a new edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign rise = in & ~r_in_q;

endmodule

// File: rtl/run_launcher.sv
// Run controller: converts a button press into a one-cycle start pulse for the
// accelerator, holds done low while the run is in progress, aborts hung runs
// after TIMEOUT_CYCLES RUN cycles and counts successfully completed runs.
module run_launcher
    import run_launcher_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             go,
    input  logic             abort,
    input  logic             acc_finish,
    output logic             start,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cnt
);

    // Timer is wide enough to hold TIMEOUT_CYCLES; it only ever counts up to
    // TIMEOUT_CYCLES-1, where the RUN state exits, so it cannot wrap.
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_timeout;
    logic [CNT_W-1:0] r_run_cnt;
    logic             w_launch_req;

    rise_detect u_go_rise (
        .clk  (clk),
        .rstn (rstn),
        .in   (go),
        .rise (w_launch_req)
    );

    // FSM with RUN timer, sticky timeout flag and completed-run counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_timeout <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Launch requests are only honoured here; acc_finish is ignored.
                    if (w_launch_req) begin
                        r_state   <= ST_LAUNCH;
                        r_timer   <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    // start pulses during this state whether or not we abort.
                    r_timer <= '0;
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Completion beats abort beats timeout.
                    if (acc_finish) begin
                        r_state   <= ST_IDLE;
                        r_run_cnt <= r_run_cnt + CNT_W'(1);
                    end else if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_timer == TMR_LAST) begin
                        r_state   <= ST_IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so reset forces them at once.
    assign start   = (r_state == ST_LAUNCH);
    assign done    = ~is_busy(r_state);
    assign timeout = r_timeout;
    assign run_cnt = r_run_cnt;

endmodule

// File: tb/tb_run_launcher.sv
// Self-checking bench for run_launcher: directed scenarios followed by a
// randomized phase, all checked against a run-age reference model.
module tb_run_launcher;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          acc_finish = 1'b0;
    logic          start;
    logic          done;
    logic          timeout;
    logic [CW-1:0] run_cnt;

    run_launcher #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .go         (go),
        .abort      (abort),
        .acc_finish (acc_finish),
        .start      (start),
        .done       (done),
        .timeout    (timeout),
        .run_cnt    (run_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: m_age = 0 idle, 1 launch cycle, n>=2 means RUN cycle n-1.
    int n_cmp = 0;
    int n_bad = 0;
    int m_age = 0;
    bit m_prev = 1'b0;
    bit m_to = 1'b0;
    int m_cnt = 0;
    int starts_seen = 0;
    int cur_low = 0;
    int last_low = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_prev = 1'b0; m_to = 1'b0; m_cnt = 0;
        cur_low = 0; last_low = 0; starts_seen = 0;
    endtask

    task automatic model_edge(input bit g, input bit a, input bit f);
        bit req;
        req = g && !m_prev;
        m_prev = g;
        if (m_age == 0) begin
            if (req) begin
                m_age = 1;
                m_to = 1'b0;
            end
        end else if (m_age == 1) begin
            m_age = a ? 0 : 2;
        end else begin
            if (f) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                m_age = 0;
            end else if (a) begin
                m_age = 0;
            end else if (m_age - 1 == TO) begin
                m_to = 1'b1;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".start"}, start, (m_age == 1) ? 1 : 0);
        check_val({tag, ".done"}, done, (m_age == 0) ? 1 : 0);
        check_val({tag, ".timeout"}, timeout, m_to ? 1 : 0);
        check_val({tag, ".run_cnt"}, run_cnt, m_cnt);
    endtask

    // One clock: drive inputs, let the edge happen, update model, check.
    task automatic step(input string tag, input bit g, input bit a, input bit f);
        go = g; abort = a; acc_finish = f;
        @(posedge clk);
        model_edge(g, a, f);
        #1;
        check_outputs(tag);
        if (start) starts_seen++;
        if (!done) begin
            cur_low++;
        end else begin
            if (cur_low != 0) last_low = cur_low;
            cur_low = 0;
        end
    endtask

    // Assert reset between edges, check the asynchronous effect, release later.
    task automatic do_reset(input string tag, input bit g);
        #1 rstn = 1'b0;
        go = g; abort = 1'b0; acc_finish = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        int s0;
        // Reset values while reset is held from time zero.
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Scenario 1: press at cycle 5, finish on 3rd RUN cycle -> done low 4.
        for (int i = 0; i < 4; i++) step("s1.idle", 0, 0, 0);
        step("s1.press", 1, 0, 0);
        check_val("s1.start_hi", start, 1);
        step("s1.run", 1, 0, 0);
        step("s1.run", 1, 0, 0);
        step("s1.run", 1, 0, 0);
        step("s1.fin", 1, 0, 1);
        step("s1.after", 0, 0, 0);
        check_val("s1.done_low_len", last_low, 4);
        check_val("s1.starts", starts_seen, 1);
        check_val("s1.run_cnt", run_cnt, 1);

        // Scenario 2: no finish -> timeout after 17 low cycles, then clear.
        step("s2.press", 1, 0, 0);
        for (int i = 0; i < TO + 3; i++) step("s2.wait", 0, 0, 0);
        check_val("s2.done_low_len", last_low, TO + 1);
        check_val("s2.timeout", timeout, 1);
        check_val("s2.run_cnt", run_cnt, 1);
        step("s2.press2", 1, 0, 0);
        check_val("s2.timeout_cleared", timeout, 0);
        step("s2.run", 1, 0, 0);
        step("s2.fin", 1, 0, 1);

        // Scenario 3: go held through a run and 10 more cycles -> one start.
        step("s3.rel", 0, 0, 0);
        s0 = starts_seen;
        step("s3.press", 1, 0, 0);
        step("s3.run", 1, 0, 0);
        step("s3.fin", 1, 0, 1);
        for (int i = 0; i < 10; i++) step("s3.hold", 1, 0, 0);
        check_val("s3.one_start", starts_seen - s0, 1);
        step("s3.rel2", 0, 0, 0);
        step("s3.press2", 1, 0, 0);
        check_val("s3.relaunch", start, 1);
        step("s3.run", 0, 0, 0);
        step("s3.fin", 0, 0, 1);

        // Scenario 4: finish+abort together counts; finish at last timer value counts.
        s0 = run_cnt;
        step("s4.press", 1, 0, 0);
        step("s4.run", 0, 0, 0);
        step("s4.both", 0, 1, 1);
        check_val("s4.both_counted", run_cnt, (s0 + 1) % 16);
        step("s4.press2", 1, 0, 0);
        step("s4.run", 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) step("s4.wait", 0, 0, 0);
        step("s4.fin_last", 0, 0, 1);
        check_val("s4.last_counted", run_cnt, (s0 + 2) % 16);
        check_val("s4.no_timeout", timeout, 0);

        // Scenario 5: abort in LAUNCH; finish held in IDLE has no effect.
        s0 = run_cnt;
        step("s5.press", 1, 0, 0);
        step("s5.abort", 1, 1, 0);
        check_val("s5.idle", done, 1);
        for (int i = 0; i < 5; i++) step("s5.fin_idle", 0, 0, 1);
        check_val("s5.cnt_same", run_cnt, s0);

        // Scenario 6: 16 runs wrap the counter; then reset mid-run.
        do_reset("s6.rst", 0);
        for (int r = 0; r < 16; r++) begin
            step("s6.press", 1, 0, 0);
            step("s6.run", 0, 0, 0);
            step("s6.fin", 0, 0, 1);
            if (r == 14) check_val("s6.cnt15", run_cnt, 15);
        end
        check_val("s6.wrap", run_cnt, 0);
        step("s6.press", 1, 0, 0);
        step("s6.run", 1, 0, 0);
        do_reset("s6.midrun_rst", 1);
        // go high at reset release launches on the first edge.
        step("s6.go_at_release", 1, 0, 0);
        check_val("s6.launch_after_rst", start, 1);

        // Randomized phase against the model.
        for (int seg = 0; seg < 12; seg++) begin
            int fin_mod;
            bit g;
            fin_mod = (seg % 2 == 0) ? 3 : 60;
            g = go;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(5) == 0) g = ~g;
                step("rand", g, ($urandom_range(39) == 0), ($urandom_range(fin_mod - 1) == 0));
            end
            if (seg == 6) do_reset("rand.rst", $urandom_range(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
